// File: rtl/cpu_pkg.sv
// Shared encodings for the ID-stage hazard unit: forwarding source codes,
// the divide stall FSM state type and the register-match helper.
package cpu_pkg;

    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_EXE     = 2'd1;
    localparam logic [1:0] FWD_MEM_ALU = 2'd2;
    localparam logic [1:0] FWD_MEM_LD  = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } div_state_t;

    // r0 is hardwired to zero, so a write to it never produces a hazard.
    function automatic logic reg_match(input logic wreg, input logic [4:0] rn, input logic [4:0] r);
        return wreg && (rn != 5'd0) && (rn == r);
    endfunction

endpackage

// File: rtl/id_hazard_if.sv
// Decode-side hazard bundle: the ID instruction fields going in and the
// stall/flush/forwarding controls coming back out.
interface id_hazard_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] id_rn;
    logic       id_wreg;
    logic       id_m2reg;
    logic       id_div;
    logic       id_br_taken;
    logic       stall;
    logic       bubble;
    logic       flush;
    logic [1:0] fwda;
    logic [1:0] fwdb;
    logic       div_busy;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_rn, id_wreg, id_m2reg, id_div, id_br_taken,
        input  stall, bubble, flush, fwda, fwdb, div_busy
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_rn, id_wreg, id_m2reg, id_div, id_br_taken,
        output stall, bubble, flush, fwda, fwdb, div_busy
    );
endinterface

// File: rtl/div_stall_ctr.sv
// Holds a divide in ID for DIV_LAT cycles: one launch cycle in IDLE followed
// by DIV_LAT-1 counted cycles in BUSY; the cnt==0 BUSY cycle releases it.
module div_stall_ctr
    import cpu_pkg::*;
#(
    parameter int DIV_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    output logic div_stall,
    output logic busy
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    div_stall = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = CNT_W'(DIV_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    div_stall = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end else begin
                    // Release cycle: the divide moves to EXE, so no relaunch here.
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == BUSY);

endmodule

// File: rtl/id_hazard_unit.sv
// ID-stage hazard controller: shadows EXE/MEM destinations, picks operand
// forwarding sources, and raises stall/bubble/flush for load-use, divide and branches.
module id_hazard_unit
    import cpu_pkg::*;
#(
    parameter int DIV_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        clr,
    id_hazard_if.slave  hz
);

    logic [4:0] exe_rn_q, exe_rn_d;
    logic       exe_wreg_q, exe_wreg_d;
    logic       exe_m2reg_q, exe_m2reg_d;
    logic [4:0] mem_rn_q, mem_rn_d;
    logic       mem_wreg_q, mem_wreg_d;
    logic       mem_m2reg_q, mem_m2reg_d;

    logic       load_use;
    logic       div_start;
    logic       div_stall;
    logic       div_busy_raw;
    logic       stall_raw;
    logic [1:0] fwda_raw, fwdb_raw;

    function automatic logic [1:0] fwd_sel(input logic [4:0] r);
        if (reg_match(exe_wreg_q, exe_rn_q, r) && !exe_m2reg_q)
            return FWD_EXE;
        else if (reg_match(mem_wreg_q, mem_rn_q, r))
            return mem_m2reg_q ? FWD_MEM_LD : FWD_MEM_ALU;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        load_use  = exe_m2reg_q &&
                    ((hz.id_use_rs && reg_match(exe_wreg_q, exe_rn_q, hz.id_rs)) ||
                     (hz.id_use_rt && reg_match(exe_wreg_q, exe_rn_q, hz.id_rt)));
        // A divide behind a load waits for the load-use bubble before launching.
        div_start = hz.id_div && !load_use;
        stall_raw = load_use || div_stall;
        fwda_raw  = fwd_sel(hz.id_rs);
        fwdb_raw  = fwd_sel(hz.id_rt);
    end

    div_stall_ctr #(
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_div_stall_ctr (
        .clk       (clk),
        .clr       (clr),
        .start     (div_start),
        .div_stall (div_stall),
        .busy      (div_busy_raw)
    );

    always_comb begin
        exe_rn_d    = stall_raw ? 5'd0 : hz.id_rn;
        exe_wreg_d  = stall_raw ? 1'b0 : hz.id_wreg;
        exe_m2reg_d = stall_raw ? 1'b0 : hz.id_m2reg;
        mem_rn_d    = exe_rn_q;
        mem_wreg_d  = exe_wreg_q;
        mem_m2reg_d = exe_m2reg_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            exe_rn_q    <= 5'd0;
            exe_wreg_q  <= 1'b0;
            exe_m2reg_q <= 1'b0;
            mem_rn_q    <= 5'd0;
            mem_wreg_q  <= 1'b0;
            mem_m2reg_q <= 1'b0;
        end else begin
            exe_rn_q    <= exe_rn_d;
            exe_wreg_q  <= exe_wreg_d;
            exe_m2reg_q <= exe_m2reg_d;
            mem_rn_q    <= mem_rn_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_m2reg_q <= mem_m2reg_d;
        end
    end

    // Outputs are held low for as long as clr is asserted.
    always_comb begin
        hz.stall    = !clr && stall_raw;
        hz.bubble   = !clr && stall_raw;
        hz.flush    = !clr && hz.id_br_taken && !stall_raw;
        hz.fwda     = clr ? FWD_RF : fwda_raw;
        hz.fwdb     = clr ? FWD_RF : fwdb_raw;
        hz.div_busy = !clr && div_busy_raw;
    end

endmodule
